// File: rtl/psum_writeback_pkg.sv
// psum_writeback shared types and constants.
// Saturation bounds and FSM encodings also used by the pooling stage.
package psum_writeback_pkg;

  localparam logic RstEnable = 1'b0;

  localparam int GS_W  = 11;
  localparam int PIX_W = 8;

  localparam logic signed [PIX_W-1:0] SAT_MAX = 8'sh7f;
  localparam logic signed [PIX_W-1:0] SAT_MIN = 8'sh80;

  typedef enum logic [1:0] {
    PWB_IDLE  = 2'd0,
    PWB_ACCUM = 2'd1,
    PWB_DONE  = 2'd2
  } pwb_state_t;

endpackage

// File: rtl/psum_writeback_if.sv
// Group-sum stream in, output feature-map buffer write port out.
// master = upstream/buffer side, slave = psum_writeback.
interface psum_writeback_if
  import psum_writeback_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic                     wb_en;
  logic signed [GS_W-1:0]   groupsum_in;
  logic                     finish_wb;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic signed [PIX_W-1:0]  mem_wdata;

  modport master (
    output wb_en, groupsum_in, finish_wb,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wb_en, groupsum_in, finish_wb,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/psum_sat.sv
// ACC_W -> 8-bit signed saturator; PSUM_RELU_EN adds a ReLU clamp.
// Shared with the pooling stage.
module psum_sat
  import psum_writeback_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic signed [ACC_W-1:0] i_sum,
  output logic signed [PIX_W-1:0] o_pix
);

  localparam logic signed [ACC_W-1:0] HiLim = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LoLim = ACC_W'(SAT_MIN);

  logic signed [PIX_W-1:0] w_sat;

  always_comb begin
    w_sat = i_sum[PIX_W-1:0];
    if (i_sum > HiLim) begin
      w_sat = SAT_MAX;
    end else if (i_sum < LoLim) begin
      w_sat = SAT_MIN;
    end
  end

`ifdef PSUM_RELU_EN
  assign o_pix = w_sat[PIX_W-1] ? '0 : w_sat;
`else
  assign o_pix = w_sat;
`endif

endmodule

// File: rtl/psum_writeback.sv
// Accumulates group sums into pixels and writes them to the ofmap buffer.
// Optional ReLU clamp via PSUM_RELU_EN (see psum_sat).
module psum_writeback
  import psum_writeback_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int ADDR_W      = 10,
  parameter int OFMAP_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [3:0]        i_group_len,
  psum_writeback_if.slave   bus,
  output logic              o_done,
  output logic              o_err_partial
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(OFMAP_DEPTH - 1);

  pwb_state_t              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_cnt;
  logic [3:0]              r_len;
  logic                    r_fin_d;
  logic                    r_we;
  logic [ADDR_W-1:0]       r_addr;
  logic signed [PIX_W-1:0] r_wdata;
  logic                    r_done;
  logic                    r_err;

  logic signed [ACC_W-1:0] w_sum;
  logic signed [PIX_W-1:0] w_pix;
  logic                    w_last;
  logic                    w_fall;
  logic [ADDR_W-1:0]       w_addr_inc;
  logic [ADDR_W-1:0]       w_wr_addr;

  assign w_sum  = r_acc + ACC_W'(bus.groupsum_in);
  assign w_last = bus.wb_en && (r_cnt == r_len - 4'd1);
  assign w_fall = r_fin_d && !bus.finish_wb;

  assign w_addr_inc = (r_addr == LastAddr) ? '0
                    : r_addr + ADDR_W'(1);
  // Address the next write will land on, given a write may be in flight.
  assign w_wr_addr  = r_we ? w_addr_inc : r_addr;

  psum_sat #(
    .ACC_W (ACC_W)
  ) u_sat (
    .i_sum (w_sum),
    .o_pix (w_pix)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state <= PWB_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_len   <= 4'd1;
      r_fin_d <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_fin_d <= bus.finish_wb;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      if (r_we) begin
        r_addr <= w_addr_inc;
      end
      if (i_start) begin
        r_state <= PWB_ACCUM;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_err   <= 1'b0;
        r_len   <= (i_group_len == 4'd0) ? 4'd1
                 : i_group_len;
      end else begin
        unique case (r_state)
          PWB_ACCUM: begin
            if (w_last) begin
              r_acc   <= '0;
              r_cnt   <= '0;
              r_we    <= 1'b1;
              r_wdata <= w_pix;
              if (w_wr_addr == LastAddr || w_fall) begin
                r_done  <= 1'b1;
                r_state <= PWB_DONE;
              end
            end else if (w_fall) begin
              r_done  <= 1'b1;
              r_state <= PWB_DONE;
              r_acc   <= '0;
              r_cnt   <= '0;
              if (r_cnt != 4'd0) begin
                r_err <= 1'b1;
              end
            end else if (bus.wb_en) begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + 4'd1;
            end
          end
          PWB_IDLE, PWB_DONE: begin
          end
          default: begin
            r_state <= PWB_IDLE;
          end
        endcase
      end
    end
  end

  // start in the write cycle cancels that write.
  assign bus.mem_we    = r_we && !i_start;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_done        = r_done;
  assign o_err_partial = r_err;

endmodule

// File: tb/tb_psum_writeback.sv
// Scoreboard bench for psum_writeback (OFMAP_DEPTH=8 for a short wrap).
// Expected writes/done pulses are queued by stimulus, popped by a monitor.
module tb_psum_writeback;

  localparam int AW = 3;
  localparam int DEPTH = 8;

  typedef struct {
    bit we;
    int addr;
    int data;
    bit done;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic [3:0] i_group_len;
  logic       o_done;
  logic       o_err_partial;

  int n_cmp;
  int n_bad;
  exp_t q[$];
  exp_t e;

  psum_writeback_if #(.ADDR_W(AW)) bus ();

  psum_writeback #(
    .ACC_W       (16),
    .ADDR_W      (AW),
    .OFMAP_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_group_len   (i_group_len),
    .bus           (bus.slave),
    .o_done        (o_done),
    .o_err_partial (o_err_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string n, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endfunction

  task automatic push(bit we, int a, int d, bit dn);
    exp_t x;
    x.we = we;
    x.addr = a;
    x.data = d;
    x.done = dn;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(int v);
    bus.wb_en = 1'b1;
    bus.groupsum_in = 11'(v);
    tick();
    bus.wb_en = 1'b0;
  endtask

  task automatic start(int len);
    i_start = 1'b1;
    i_group_len = 4'(len);
    tick();
    i_start = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_we"}, int'(bus.mem_we), 0);
    chk({tag, "_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, int'(bus.mem_wdata), 0);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_err"}, int'(o_err_partial), 0);
  endtask

  always @(negedge clk) begin
    if (bus.mem_we || o_done) begin
      if (q.size() == 0) begin
        chk("spurious_we", int'(bus.mem_we), 0);
        chk("spurious_done", int'(o_done), 0);
      end else begin
        e = q.pop_front();
        chk("we", int'(bus.mem_we), int'(e.we));
        chk("done", int'(o_done), int'(e.done));
        if (e.we) begin
          chk("addr", int'(bus.mem_addr), e.addr);
          chk("data", int'(bus.mem_wdata), e.data);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    i_start = 1'b0;
    i_group_len = 4'd0;
    bus.wb_en = 1'b0;
    bus.groupsum_in = '0;
    bus.finish_wb = 1'b0;
    idle(2);
    chk_zero("reset");
    rst = 1'b1;
    idle(1);
    beat(5);
    idle(2);

    // 100-20+50 = 130 saturates to 127
    start(3);
    beat(100);
    beat(-20);
    push(1, 0, 127, 0);
    beat(50);
    idle(3);

    // -290 saturates low
    start(2);
    beat(-300);
`ifdef PSUM_RELU_EN
    push(1, 0, 0, 0);
`else
    push(1, 0, -128, 0);
`endif
    beat(10);
    beat(-5);
`ifdef PSUM_RELU_EN
    push(1, 1, 0, 0);
`else
    push(1, 1, -2, 0);
`endif
    beat(3);
    idle(3);

    // group_len 0 behaves as 1
    start(0);
    push(1, 0, 7, 0);
    beat(7);
    idle(3);

    // back-to-back single-beat pixels
    start(1);
    for (int i = 1; i <= 5; i++) begin
      push(1, i - 1, i, 0);
      beat(i);
    end
    idle(3);

    // wrap at last address
    start(1);
    for (int i = 0; i < DEPTH; i++) begin
      push(1, i, i + 10, i == DEPTH - 1);
      beat(i + 10);
    end
    beat(50);
    chk("wrap_addr", int'(bus.mem_addr), 0);
    idle(3);

    // partial pixel at end of stream
    start(3);
    beat(1);
    beat(2);
    bus.finish_wb = 1'b1;
    tick();
    bus.finish_wb = 1'b0;
    push(0, 0, 0, 1);
    tick();
    idle(1);
    chk("err_set", int'(o_err_partial), 1);
    beat(5);
    idle(2);
    chk("err_sticky", int'(o_err_partial), 1);
    start(2);
    chk("err_clear", int'(o_err_partial), 0);

    // last beat coincident with finish_wb fall
    bus.finish_wb = 1'b1;
    beat(3);
    bus.finish_wb = 1'b0;
    push(1, 0, 7, 1);
    beat(4);
    idle(2);
    chk("coinc_err", int'(o_err_partial), 0);
    beat(9);
    idle(2);

    // start right after a last beat cancels the write
    start(2);
    beat(5);
    beat(6);
    i_start = 1'b1;
    i_group_len = 4'd2;
    tick();
    i_start = 1'b0;
    idle(2);
    chk("abort_addr", int'(bus.mem_addr), 0);

    // async reset mid-accumulation
    push(1, 0, 18, 0);
    beat(9);
    beat(9);
    idle(2);
    chk("pre_rst_addr", int'(bus.mem_addr), 1);
    beat(9);
    #2 rst = 1'b0;
    #1;
    chk_zero("abort_rst");
    tick();
    rst = 1'b1;
    beat(9);
    beat(9);
    idle(3);
    chk_zero("post_rst");

    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
